seg7_result_scan: RTL and testbench

//  Downstream display stage for the CPU's 32-bit result bus. Latches the result

---
 rtl/seg7_result_scan.sv | 147 ++++++++++++++
 tb/tb_seg7_result_scan.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg7_result_scan.sv
// Purpose: latches the CPU result word and scans it as 8 hex digits on a
//          common-anode 7-segment array.
// Latency: one cycle from value_valid to shown; one cycle from (state, idx, shown) to an/seg/dp.
// Backpressure: none; value_valid is a load strobe, and freeze drops it.
//
// Ports:
//   clk, reset   posedge clock, synchronous active-high reset
//   value        32-bit result word, loaded when value_valid=1 and freeze=0
//   freeze       holds the displayed word and lights dp on digit 0
//   blank_lz     blanks leading-zero digits; digit 0 is never blanked
//   shown        latched word being displayed
//   an/seg/dp    anode enables, segments {g,f,e,d,c,b,a}, decimal point
module seg7_result_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        value_valid,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [31:0] shown,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0] PC_BLANK = PC_W'(BLANK_CYC);

    // Inactive levels depend on output polarity.
    localparam logic [7:0] AN_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     shown_q, shown_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic [4:0]      nib_lsb;
    logic [3:0]      nibble;
    logic [31:0]     upper;
    logic            lz_blanked;
    logic            slot_wrap;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Digit selection and leading-zero detection for the current slot.
    always_comb begin
        nib_lsb    = {idx_q, 2'b00};
        nibble     = shown_q[nib_lsb +: 4];
        upper      = shown_q >> nib_lsb;
        // Digit idx is blanked when it and every more significant nibble are zero.
        lz_blanked = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);
    end

    // Scan prescaler, slot index and per-slot BLANK/DRIVE state.
    always_comb begin
        slot_wrap = (pc_q == PC_LAST);
        pc_d      = slot_wrap ? '0 : pc_q + 1'b1;
        idx_d     = slot_wrap ? idx_q + 3'd1 : idx_q;
        state_d   = state_q;
        case (state_q)
            ST_BLANK: if (pc_d == PC_BLANK) state_d = ST_DRIVE;
            ST_DRIVE: if (slot_wrap)        state_d = ST_BLANK;
            default:                        state_d = ST_BLANK;
        endcase
    end

    // Word latch and registered display drive.
    always_comb begin
        shown_d = shown_q;
        if (value_valid && !freeze) begin
            shown_d = value;
        end

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        if (state_q == ST_DRIVE && !lz_blanked) begin
            an_d  = ACTIVE_LOW ? ~(8'h01 << idx_q) : (8'h01 << idx_q);
            seg_d = ACTIVE_LOW ? ~hex7(nibble) : hex7(nibble);
            if (idx_q == 3'd0 && freeze) begin
                dp_d = ~DP_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            pc_q    <= '0;
            idx_q   <= 3'd0;
            shown_q <= 32'd0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            shown_q <= shown_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign shown = shown_q;
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_seg7_result_scan.sv
// Bench for seg7_result_scan: directed scenarios followed by random traffic,
// predicted by a cycle-count model and checked by a decoupled scoreboard monitor.
module tb_seg7_result_scan;

    localparam int SD = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        value_valid;
    logic        freeze;
    logic        blank_lz;
    logic [31:0] shown;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    typedef struct {
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [31:0] shown;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Model state: cycles since reset release, and the latched word.
    int          m_cyc   = 0;
    logic [31:0] m_shown = 32'd0;
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_result_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
        .freeze(freeze), .blank_lz(blank_lz), .shown(shown), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, predict what the DUT shows after the coming edge.
    task automatic cycle(input logic rst, input logic [31:0] v, input logic vv,
                         input logic fr, input logic lz);
        exp_t e;
        int   pc, idx;
        logic drive, blanked;
        logic [3:0] nib;
        reset = rst; value = v; value_valid = vv; freeze = fr; blank_lz = lz;
        if (rst) begin
            e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.shown = 32'd0;
            m_shown = 32'd0;
            m_cyc   = 0;
        end else begin
            pc      = m_cyc % SD;
            idx     = (m_cyc / SD) % 8;
            drive   = (pc >= BC);
            blanked = lz && idx > 0 && ((m_shown >> (4 * idx)) == 32'd0);
            nib     = 4'((m_shown >> (4 * idx)) & 32'hF);
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            if (drive && !blanked) begin
                e.an  = ~(8'h01 << idx);
                e.seg = ~hex_tab[nib];
                if (idx == 0 && fr) e.dp = 1'b0;
            end
            if (vv && !fr) m_shown = v;
            e.shown = m_shown;
            m_cyc   = (m_cyc + 1) % (SD * 8);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: output registers update on every edge, so one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total += 4;
                if (an !== e.an) begin
                    bad++;
                    $display("FAIL an: got %h want %h at %0t", an, e.an, $time);
                end
                if (seg !== e.seg) begin
                    bad++;
                    $display("FAIL seg: got %h want %h at %0t", seg, e.seg, $time);
                end
                if (dp !== e.dp) begin
                    bad++;
                    $display("FAIL dp: got %b want %b at %0t", dp, e.dp, $time);
                end
                if (shown !== e.shown) begin
                    bad++;
                    $display("FAIL shown: got %h want %h at %0t", shown, e.shown, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        // Reset held 3 cycles, then idle scanning of zero.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        // Load 1234ABCD and scan several full rotations.
        cycle(1'b0, 32'h1234ABCD, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Freeze drops a strobe; dp lights on digit 0.
        cycle(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        // Leading-zero blanking on A5, then on zero.
        cycle(1'b0, 32'h000000A5, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        // Reset in the middle of digit 5 DRIVE, then restart from digit 0.
        cycle(1'b0, 32'h89ABCDEF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !((m_cyc / SD) % 8 == 5 && m_cyc % SD == 2); i++)
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Random traffic; shifted values exercise leading-zero blanking.
        for (int i = 0; i < 3000; i++) begin
            rv = $urandom >> $urandom_range(0, 32);
            cycle(($urandom_range(0, 199) == 0), rv, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
